// File: rtl/harness_pkg.sv
// harness_pkg
//   Shared definitions for the simulation run controller:
//   - status codes driven on sim_harness_ctrl.status
//   - default tohost store address
//   - controller state enum and small helpers mapping a state to its
//     externally visible status / terminal flag
package harness_pkg;

  localparam logic [2:0] STATUS_HOLD    = 3'd0;
  localparam logic [2:0] STATUS_RUN     = 3'd1;
  localparam logic [2:0] STATUS_PASS    = 3'd2;
  localparam logic [2:0] STATUS_FAIL    = 3'd3;
  localparam logic [2:0] STATUS_TIMEOUT = 3'd4;
  localparam logic [2:0] STATUS_HANG    = 3'd5;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0FFC;

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_RUN        = 3'd1,
    S_PASS       = 3'd2,
    S_FAIL       = 3'd3,
    S_TIMEOUT    = 3'd4,
    S_HANG       = 3'd5
  } state_e;

  // Externally visible status code for a controller state.
  function automatic logic [2:0] status_of(input state_e s);
    logic [2:0] code;
    case (s)
      S_RESET_HOLD: code = STATUS_HOLD;
      S_RUN:        code = STATUS_RUN;
      S_PASS:       code = STATUS_PASS;
      S_FAIL:       code = STATUS_FAIL;
      S_TIMEOUT:    code = STATUS_TIMEOUT;
      S_HANG:       code = STATUS_HANG;
      default:      code = STATUS_HOLD;
    endcase
    return code;
  endfunction

  // True for the states that end a run and wait for restart.
  function automatic logic is_terminal(input state_e s);
    logic term;
    case (s)
      S_PASS, S_FAIL, S_TIMEOUT, S_HANG: term = 1'b1;
      default:                           term = 1'b0;
    endcase
    return term;
  endfunction

endpackage

// File: rtl/hang_detector.sv
// hang_detector
//   Watches the core PC during RUN and flags a self-loop.
//   hang is asserted combinationally in the RUN cycle that would be the
//   LOOP_LIMIT-th consecutive cycle with an unchanged PC.
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   run   controller is in RUN; low clears all tracking state
//   pc    core program counter
//   hang  self-loop detected this cycle
module hang_detector #(
  parameter int XLEN       = 32,
  parameter int LOOP_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [XLEN-1:0] pc,
  output logic            hang
);

  // Counter only needs to reach LOOP_LIMIT-2: any hang takes the
  // controller out of RUN, which clears it.
  localparam int LOOP_W = (LOOP_LIMIT > 2) ? $clog2(LOOP_LIMIT) : 1;
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOP_LIMIT - 2);
  localparam logic [LOOP_W-1:0] LOOP_ONE  = LOOP_W'(1'b1);

  logic [XLEN-1:0]   pc_q_r;
  logic              pc_valid_r;
  logic [LOOP_W-1:0] loop_r;
  logic              same_s;

  // pc_valid guards the first RUN cycle, where pc_q holds no real sample.
  assign same_s = pc_valid_r && (pc == pc_q_r);
  assign hang   = same_s && (loop_r == LOOP_LAST);

  // PC history and equal-run counter; cleared whenever not running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q_r     <= {XLEN{1'b0}};
      pc_valid_r <= 1'b0;
      loop_r     <= {LOOP_W{1'b0}};
    end else if (run) begin
      pc_q_r     <= pc;
      pc_valid_r <= 1'b1;
      loop_r     <= same_s ? (loop_r + LOOP_ONE) : {LOOP_W{1'b0}};
    end else begin
      pc_q_r     <= {XLEN{1'b0}};
      pc_valid_r <= 1'b0;
      loop_r     <= {LOOP_W{1'b0}};
    end
  end

endmodule

// File: rtl/sim_harness_ctrl.sv
// sim_harness_ctrl
//   Run controller for the single-cycle RISC-V core: holds the core in
//   reset for RST_CYCLES edges, runs it, and ends the run on a tohost
//   store (PASS/FAIL), a cycle budget (TIMEOUT) or a PC self-loop (HANG).
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   restart      in a terminal state, start a new reset/run sequence
//   pc           core program counter (snooped)
//   mem_we       core data-memory write enable (snooped)
//   mem_addr     core data-memory address (snooped)
//   mem_wdata    core data-memory write data (snooped)
//   core_rst_n   active-low reset to the core, registered
//   done         high in any terminal state
//   pass         high only in PASS
//   status       0 HOLD, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 HANG
//   cycle_count  RUN cycles elapsed, frozen in terminal states
//   fail_code    mem_wdata>>1 of a failing tohost store
module sim_harness_ctrl
  import harness_pkg::*;
#(
  parameter int              RST_CYCLES  = 2,
  parameter int              MAX_CYCLES  = 1000,
  parameter int              LOOP_LIMIT  = 8,
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic [XLEN-1:0]  pc,
  input  logic             mem_we,
  input  logic [XLEN-1:0]  mem_addr,
  input  logic [XLEN-1:0]  mem_wdata,
  output logic             core_rst_n,
  output logic             done,
  output logic             pass,
  output logic [2:0]       status,
  output logic [CNT_W-1:0] cycle_count,
  output logic [XLEN-1:0]  fail_code
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
  localparam logic [XLEN-1:0]   PASS_WORD = XLEN'(1'b1);

  state_e            state_r, state_s;
  logic [HOLD_W-1:0] hold_r, hold_s;
  logic [CNT_W-1:0]  cycle_count_r, cycle_count_s;
  logic [XLEN-1:0]   fail_code_r, fail_code_s;
  logic              core_rst_n_r, core_rst_n_s;
  logic              done_r, done_s;
  logic              pass_r, pass_s;
  logic [2:0]        status_r, status_s;
  logic              tohost_s, budget_s, hang_s, run_s;

  assign run_s    = (state_r == S_RUN);
  assign tohost_s = mem_we && (mem_addr == TOHOST_ADDR);
  assign budget_s = (cycle_count_r == CNT_LAST);

  hang_detector #(
    .XLEN       (XLEN),
    .LOOP_LIMIT (LOOP_LIMIT)
  ) u_hang (
    .clk  (clk),
    .rst  (rst),
    .run  (run_s),
    .pc   (pc),
    .hang (hang_s)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_RESET_HOLD;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; in RUN the tohost store outranks budget, budget outranks hang.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_RESET_HOLD: begin
        if (hold_r == HOLD_LAST) state_s = S_RUN;
        else                     state_s = S_RESET_HOLD;
      end
      S_RUN: begin
        if (tohost_s) begin
          if (mem_wdata == PASS_WORD) state_s = S_PASS;
          else                        state_s = S_FAIL;
        end else if (budget_s) begin
          state_s = S_TIMEOUT;
        end else if (hang_s) begin
          state_s = S_HANG;
        end else begin
          state_s = S_RUN;
        end
      end
      S_PASS, S_FAIL, S_TIMEOUT, S_HANG: begin
        if (restart) state_s = S_RESET_HOLD;
        else         state_s = state_r;
      end
      default: state_s = S_RESET_HOLD;
    endcase
  end

  // Hold counter, cycle counter and fail-code capture.
  always_comb begin
    cycle_count_s = cycle_count_r;
    fail_code_s   = fail_code_r;
    if ((state_r == S_RESET_HOLD) && (state_s == S_RESET_HOLD)) begin
      hold_s = hold_r + HOLD_ONE;
    end else begin
      hold_s = {HOLD_W{1'b0}};
    end
    case (state_r)
      S_RESET_HOLD: begin
        cycle_count_s = {CNT_W{1'b0}};
        fail_code_s   = {XLEN{1'b0}};
      end
      S_RUN: begin
        if (state_s == S_RUN) cycle_count_s = cycle_count_r + CNT_ONE;
        else                  cycle_count_s = cycle_count_r;
        if (state_s == S_FAIL) fail_code_s = {1'b0, mem_wdata[XLEN-1:1]};
        else                   fail_code_s = fail_code_r;
      end
      S_PASS, S_FAIL, S_TIMEOUT, S_HANG: begin
        if (restart) begin
          cycle_count_s = {CNT_W{1'b0}};
          fail_code_s   = {XLEN{1'b0}};
        end else begin
          cycle_count_s = cycle_count_r;
          fail_code_s   = fail_code_r;
        end
      end
      default: begin
        cycle_count_s = {CNT_W{1'b0}};
        fail_code_s   = {XLEN{1'b0}};
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track state_r.
  always_comb begin
    core_rst_n_s = (state_s == S_RUN);
    status_s     = status_of(state_s);
    done_s       = is_terminal(state_s);
    pass_s       = (state_s == S_PASS);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_r        <= {HOLD_W{1'b0}};
      cycle_count_r <= {CNT_W{1'b0}};
      fail_code_r   <= {XLEN{1'b0}};
      core_rst_n_r  <= 1'b0;
      status_r      <= STATUS_HOLD;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
    end else begin
      hold_r        <= hold_s;
      cycle_count_r <= cycle_count_s;
      fail_code_r   <= fail_code_s;
      core_rst_n_r  <= core_rst_n_s;
      status_r      <= status_s;
      done_r        <= done_s;
      pass_r        <= pass_s;
    end
  end

  assign core_rst_n  = core_rst_n_r;
  assign status      = status_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign cycle_count = cycle_count_r;
  assign fail_code   = fail_code_r;

endmodule

// File: tb/tb_sim_harness_ctrl.sv
// tb_sim_harness_ctrl
//   Directed bench for sim_harness_ctrl with RST_CYCLES=3, MAX_CYCLES=20,
//   LOOP_LIMIT=8. Inputs change and outputs are sampled on the falling edge.
module tb_sim_harness_ctrl;

  logic        clk;
  logic        rst;
  logic        restart;
  logic [31:0] pc;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst_n;
  logic        done;
  logic        pass;
  logic [2:0]  status;
  logic [31:0] cycle_count;
  logic [31:0] fail_code;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] TOHOST = 32'h0000_0FFC;

  sim_harness_ctrl #(
    .RST_CYCLES  (3),
    .MAX_CYCLES  (20),
    .LOOP_LIMIT  (8),
    .XLEN        (32),
    .CNT_W       (32),
    .TOHOST_ADDR (32'h0000_0FFC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .restart     (restart),
    .pc          (pc),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_rst_n  (core_rst_n),
    .done        (done),
    .pass        (pass),
    .status      (status),
    .cycle_count (cycle_count),
    .fail_code   (fail_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, then step to the next falling edge.
  task automatic cyc(input logic [31:0] p, input logic we, input logic [31:0] a, input logic [31:0] d);
    pc        = p;
    mem_we    = we;
    mem_addr  = a;
    mem_wdata = d;
    @(negedge clk);
  endtask

  // Three edges in RESET_HOLD, RUN entered on the third.
  task automatic hold_to_run(input string tag);
    cyc(32'h0, 1'b0, 32'h0, 32'h0);
    chk({tag, "_hold1_rstn"}, 32'(core_rst_n), 32'd0);
    chk({tag, "_hold1_status"}, 32'(status), 32'd0);
    cyc(32'h0, 1'b0, 32'h0, 32'h0);
    chk({tag, "_hold2_rstn"}, 32'(core_rst_n), 32'd0);
    cyc(32'h0, 1'b0, 32'h0, 32'h0);
    chk({tag, "_run_rstn"}, 32'(core_rst_n), 32'd1);
    chk({tag, "_run_status"}, 32'(status), 32'd1);
    chk({tag, "_run_count"}, cycle_count, 32'd0);
  endtask

  // One-cycle restart pulse from a terminal state.
  task automatic do_restart(input string tag);
    restart = 1'b1;
    cyc(32'h0, 1'b0, 32'h0, 32'h0);
    restart = 1'b0;
    chk({tag, "_rs_status"}, 32'(status), 32'd0);
    chk({tag, "_rs_done"}, 32'(done), 32'd0);
    chk({tag, "_rs_count"}, cycle_count, 32'd0);
    chk({tag, "_rs_fcode"}, fail_code, 32'd0);
    chk({tag, "_rs_rstn"}, 32'(core_rst_n), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    restart   = 1'b0;
    pc        = 32'h0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_rstn", 32'(core_rst_n), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_count", cycle_count, 32'd0);
    chk("rst_fcode", fail_code, 32'd0);

    rst = 1'b1;
    hold_to_run("init");

    // PASS on cycle 10; a store to another address on cycle 5 is ignored
    for (int i = 0; i < 10; i++) cyc(32'(4 * i), (i == 5), 32'h0000_0FF8, 32'h1);
    chk("pass_pre_status", 32'(status), 32'd1);
    chk("pass_pre_count", cycle_count, 32'd10);
    cyc(32'd40, 1'b1, TOHOST, 32'h1);
    chk("pass_status", 32'(status), 32'd2);
    chk("pass_pass", 32'(pass), 32'd1);
    chk("pass_done", 32'(done), 32'd1);
    chk("pass_count", cycle_count, 32'd10);
    chk("pass_rstn", 32'(core_rst_n), 32'd0);
    // tohost store outside RUN ignored, count frozen
    cyc(32'd44, 1'b1, TOHOST, 32'h7);
    chk("pass_hold_status", 32'(status), 32'd2);
    chk("pass_hold_count", cycle_count, 32'd10);
    chk("pass_hold_fcode", fail_code, 32'd0);

    // FAIL on cycle 3; restart during RUN ignored
    do_restart("fail");
    hold_to_run("fail");
    cyc(32'd0, 1'b0, 32'h0, 32'h0);
    cyc(32'd4, 1'b0, 32'h0, 32'h0);
    restart = 1'b1;
    cyc(32'd8, 1'b0, 32'h0, 32'h0);
    restart = 1'b0;
    chk("fail_rsign_status", 32'(status), 32'd1);
    chk("fail_rsign_count", cycle_count, 32'd3);
    cyc(32'd12, 1'b1, TOHOST, 32'h7);
    chk("fail_status", 32'(status), 32'd3);
    chk("fail_fcode", fail_code, 32'd3);
    chk("fail_pass", 32'(pass), 32'd0);
    chk("fail_done", 32'(done), 32'd1);
    chk("fail_count", cycle_count, 32'd3);

    // TIMEOUT after 20 RUN cycles
    do_restart("tmo");
    hold_to_run("tmo");
    for (int i = 0; i < 19; i++) cyc(32'(4 * i), 1'b0, 32'h0, 32'h0);
    chk("tmo_pre_status", 32'(status), 32'd1);
    chk("tmo_pre_count", cycle_count, 32'd19);
    cyc(32'd76, 1'b0, 32'h0, 32'h0);
    chk("tmo_status", 32'(status), 32'd4);
    chk("tmo_count", cycle_count, 32'd19);
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_pass", 32'(pass), 32'd0);

    // tohost store on the last budget cycle wins
    do_restart("last");
    hold_to_run("last");
    for (int i = 0; i < 19; i++) cyc(32'(4 * i), 1'b0, 32'h0, 32'h0);
    cyc(32'd76, 1'b1, TOHOST, 32'h1);
    chk("last_status", 32'(status), 32'd2);
    chk("last_count", cycle_count, 32'd19);

    // HANG: pc stuck at 0x40 from cycle 5, declared after cycle 12
    do_restart("hang");
    hold_to_run("hang");
    for (int i = 0; i < 12; i++) cyc((i < 5) ? 32'(4 * i) : 32'h40, 1'b0, 32'h0, 32'h0);
    chk("hang_pre_status", 32'(status), 32'd1);
    chk("hang_pre_count", cycle_count, 32'd12);
    cyc(32'h40, 1'b0, 32'h0, 32'h0);
    chk("hang_status", 32'(status), 32'd5);
    chk("hang_count", cycle_count, 32'd12);
    chk("hang_done", 32'(done), 32'd1);

    // pc changing every 7th cycle never hangs; run ends on budget
    do_restart("nohang");
    hold_to_run("nohang");
    for (int i = 0; i < 19; i++) cyc(32'h100 + 32'(4 * (i / 7)), 1'b0, 32'h0, 32'h0);
    chk("nohang_pre_status", 32'(status), 32'd1);
    cyc(32'h108, 1'b0, 32'h0, 32'h0);
    chk("nohang_status", 32'(status), 32'd4);

    // Asynchronous reset mid-RUN, then a fresh run
    do_restart("arst");
    hold_to_run("arst");
    for (int i = 0; i < 5; i++) cyc(32'(4 * i), 1'b0, 32'h0, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("arst_rstn", 32'(core_rst_n), 32'd0);
    chk("arst_status", 32'(status), 32'd0);
    chk("arst_count", cycle_count, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    hold_to_run("arst2");
    cyc(32'd0, 1'b0, 32'h0, 32'h0);
    cyc(32'd4, 1'b0, 32'h0, 32'h0);
    cyc(32'd8, 1'b1, TOHOST, 32'h1);
    chk("arst2_status", 32'(status), 32'd2);
    chk("arst2_count", cycle_count, 32'd2);
    chk("arst2_pass", 32'(pass), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
